// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback entry type.
package cpu_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular queue. Entries are exported in age order
// (index 0 = head) with a matching valid vector.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  entry_t                   push0_entry,
  input  logic                     push1,
  input  entry_t                   push1_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t [DEPTH-1:0]       entries,
  output logic [DEPTH-1:0]         entry_vld
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr1_ptr;
  entry_t           mem [DEPTH];

  // push1 lands behind push0 when both fire on the same edge
  assign wr1_ptr = wr_ptr + PTR_W'(push0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]  <= push0_entry;
    if (push1) mem[wr1_ptr] <= push1_entry;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    assign entries[k]   = mem[rd_ptr + PTR_W'(k)];
    assign entry_vld[k] = (CNT_W'(k) < count);
  end
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: ALU/load arbitration into an in-order queue feeding the
// register file write port. Optional forwarding port under WB_FWD_EN.
module writeback_stage #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int ADDR_W     = cpu_pkg::REG_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter bit DROP_R0    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_dest,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_dest,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 reg_write_en,
  output logic [ADDR_W-1:0]    reg_write_dest,
  output logic [DATA_W-1:0]    reg_write_data,
  output logic [2**ADDR_W-1:0] busy_mask,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0]    fwd_addr,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data,
`endif
  output logic                 pending
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [CNT_W-1:0]           count, free;
  entry_t [FIFO_DEPTH-1:0]    entries;
  logic [FIFO_DEPTH-1:0]      entry_vld;
  logic                       mem_push, alu_push, pop;

  // count excludes a same-edge pop, so ready never relies on pass-through
  assign free      = CNT_W'(FIFO_DEPTH) - count;
  assign mem_ready = !rst && (free >= CNT_W'(1));
  assign alu_ready = !rst && ((free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !mem_valid));

  assign mem_push = mem_valid && mem_ready && !(DROP_R0 && (mem_dest == '0));
  assign alu_push = alu_valid && alu_ready && !(DROP_R0 && (alu_dest == '0));
  assign pop      = (count != '0);

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (mem_push),
    .push0_entry ({mem_dest, mem_data}),
    .push1       (alu_push),
    .push1_entry ({alu_dest, alu_data}),
    .pop         (pop),
    .count       (count),
    .entries     (entries),
    .entry_vld   (entry_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else begin
      reg_write_en <= pop;
      if (pop) begin
        reg_write_dest <= entries[0].dest;
        reg_write_data <= entries[0].data;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    if (reg_write_en) busy_mask[reg_write_dest] = 1'b1;
    for (int k = 0; k < FIFO_DEPTH; k++)
      if (entry_vld[k]) busy_mask[entries[k].dest] = 1'b1;
  end
  assign pending = |busy_mask;

`ifdef WB_FWD_EN
  // Oldest first so the newest matching entry overwrites earlier hits
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (reg_write_en && (reg_write_dest == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = reg_write_data;
    end
    for (int k = 0; k < FIFO_DEPTH; k++)
      if (entry_vld[k] && (entries[k].dest == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[k].data;
      end
  end
`else
  logic unused_entries;
  assign unused_entries = ^entries;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (default parameters).
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [3:0]  alu_dest, mem_dest, reg_write_dest;
  logic [15:0] alu_data, mem_data, reg_write_data;
  logic        reg_write_en, pending;
  logic [15:0] busy_mask;
`ifdef WB_FWD_EN
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] rf [16];
  logic [19:0] log_q [$];

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .busy_mask(busy_mask),
`ifdef WB_FWD_EN
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .pending(pending)
  );

  // register file model plus a log of every write strobe
  always @(posedge clk) begin
    if (reg_write_en) begin
      rf[reg_write_dest] <= reg_write_data;
      log_q.push_back({reg_write_dest, reg_write_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 16'h9999;
    mem_valid = 1'b1; mem_dest = 4'd6; mem_data = 16'h6666;
    tick(); tick();
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got %b exp 0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_ready got %b exp 0", mem_ready); end
    checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL reset_wen got %b exp 0", reg_write_en); end
    checks++; if (busy_mask !== 16'h0) begin failures++; $display("FAIL reset_busy got %h exp 0000", busy_mask); end
    checks++; if ({reg_write_dest, reg_write_data} !== 20'h0) begin failures++; $display("FAIL reset_out got %h exp 00000", {reg_write_dest, reg_write_data}); end
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({reg_write_en, busy_mask} !== 17'h0) begin failures++; $display("FAIL post_reset_idle got %h exp 00000", {reg_write_en, busy_mask}); end
    end
    checks++; if (log_q.size() !== 0) begin failures++; $display("FAIL post_reset_writes got %0d exp 0", log_q.size()); end
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 16'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL single_ready got %b exp 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL single_wen_early got %b exp 0", reg_write_en); end
    checks++; if (busy_mask !== 16'h0008 || pending !== 1'b1) begin failures++; $display("FAIL single_busy_q got %h/%b exp 0008/1", busy_mask, pending); end
    tick();
    checks++; if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 4'd3, 16'h1234}) begin
      failures++; $display("FAIL single_write got %b/%h/%h exp 1/3/1234", reg_write_en, reg_write_dest, reg_write_data); end
    checks++; if (busy_mask !== 16'h0008) begin failures++; $display("FAIL single_busy_out got %h exp 0008", busy_mask); end
    tick();
    checks++; if (reg_write_en !== 1'b0 || busy_mask !== 16'h0) begin failures++; $display("FAIL single_retired got %b/%h exp 0/0000", reg_write_en, busy_mask); end
    checks++; if (rf[3] !== 16'h1234) begin failures++; $display("FAIL single_rf got %h exp 1234", rf[3]); end
  endtask

  task automatic test_dual_push();
    mem_valid = 1'b1; mem_dest = 4'd2; mem_data = 16'h5555;
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 16'hAAAA;
    #1;
    checks++; if ({mem_ready, alu_ready} !== 2'b11) begin failures++; $display("FAIL dual_ready got %b exp 11", {mem_ready, alu_ready}); end
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    checks++; if (busy_mask !== 16'h0006) begin failures++; $display("FAIL dual_busy got %h exp 0006", busy_mask); end
    tick();
    checks++; if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 4'd2, 16'h5555}) begin
      failures++; $display("FAIL dual_first got %b/%h/%h exp 1/2/5555", reg_write_en, reg_write_dest, reg_write_data); end
    tick();
    checks++; if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 4'd1, 16'hAAAA}) begin
      failures++; $display("FAIL dual_second got %b/%h/%h exp 1/1/aaaa", reg_write_en, reg_write_dest, reg_write_data); end
    checks++; if (busy_mask !== 16'h0002) begin failures++; $display("FAIL dual_busy2 got %h exp 0002", busy_mask); end
    tick();
    checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL dual_idle got %b exp 0", reg_write_en); end
  endtask

  task automatic test_fill();
    logic [5:0]  exp_alu_ready;
    logic [19:0] exp_log [8];
    int mi = 0, ai = 0;
    exp_alu_ready = 6'b100011;  // bit c = expected alu_ready in cycle c
    exp_log = '{ {4'd4, 16'h1000}, {4'd10, 16'h2000}, {4'd5, 16'h1001}, {4'd11, 16'h2001},
                 {4'd6, 16'h1002}, {4'd7, 16'h1003}, {4'd8, 16'h1004}, {4'd12, 16'h2002} };
    log_q.delete();
    for (int c = 0; c < 6; c++) begin
      mem_valid = (mi < 5); mem_dest = 4'(4 + mi); mem_data = 16'h1000 + 16'(mi);
      alu_valid = (ai < 3); alu_dest = 4'(10 + ai); alu_data = 16'h2000 + 16'(ai);
      #1;
      checks++; if (alu_ready !== exp_alu_ready[c]) begin failures++; $display("FAIL fill_alu_ready c%0d got %b exp %b", c, alu_ready, exp_alu_ready[c]); end
      if (mem_valid) begin
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL fill_mem_ready c%0d got %b exp 1", c, mem_ready); end
      end
      if (mem_valid && mem_ready) mi++;
      if (alu_valid && alu_ready) ai++;
      tick();
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (log_q.size() !== 8) begin failures++; $display("FAIL fill_count got %0d exp 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp_log[i]) begin failures++; $display("FAIL fill_order[%0d] got %h exp %h", i, log_q[i], exp_log[i]); end
    end
  endtask

  task automatic test_r0_drop();
    log_q.delete();
    alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 16'hFFFF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got %b exp 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if ({busy_mask, pending} !== 17'h0) begin failures++; $display("FAIL r0_busy got %h/%b exp 0000/0", busy_mask, pending); end
    tick();
    checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL r0_wen got %b exp 0", reg_write_en); end
    // r0 load beside a real ALU write: only r9 may retire
    mem_valid = 1'b1; mem_dest = 4'd0; mem_data = 16'h0BAD;
    alu_valid = 1'b1; alu_dest = 4'd9; alu_data = 16'h0909;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    checks++; if (busy_mask !== 16'h0200) begin failures++; $display("FAIL r0_mix_busy got %h exp 0200", busy_mask); end
    tick();
    checks++; if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 4'd9, 16'h0909}) begin
      failures++; $display("FAIL r0_mix_write got %b/%h/%h exp 1/9/0909", reg_write_en, reg_write_dest, reg_write_data); end
    tick(); tick();
    checks++; if (log_q.size() !== 1) begin failures++; $display("FAIL r0_write_count got %0d exp 1", log_q.size()); end
  endtask

  task automatic test_reset_mid();
    log_q.delete();
    mem_valid = 1'b1; mem_dest = 4'd6; mem_data = 16'h0666;
    alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 16'h0777;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({reg_write_en, busy_mask} !== 17'h0) begin failures++; $display("FAIL midrst_state got %h exp 00000", {reg_write_en, busy_mask}); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (log_q.size() !== 0) begin failures++; $display("FAIL midrst_writes got %0d exp 0", log_q.size()); end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    alu_valid = 1'b1; alu_dest = 4'd4; alu_data = 16'h0001;
    tick();
    alu_data = 16'h0002;
    tick();
    alu_valid = 1'b0;
    fwd_addr = 4'd4; #1;
    checks++; if ({fwd_hit, fwd_data} !== {1'b1, 16'h0002}) begin failures++; $display("FAIL fwd_hit4 got %b/%h exp 1/0002", fwd_hit, fwd_data); end
    fwd_addr = 4'd7; #1;
    checks++; if ({fwd_hit, fwd_data} !== {1'b0, 16'h0000}) begin failures++; $display("FAIL fwd_miss7 got %b/%h exp 0/0000", fwd_hit, fwd_data); end
    tick(); tick(); tick();
  endtask
`endif

  initial begin
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_dest = '0; alu_data = '0; mem_dest = '0; mem_data = '0;
`ifdef WB_FWD_EN
    fwd_addr = '0;
`endif
    for (int i = 0; i < 16; i++) rf[i] = '0;
    test_reset();
    test_single();
    test_dual_push();
    test_fill();
    test_r0_drop();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage, directly upstream of the 16x16-bit register file.
- Collects results from two producers, the ALU and the memory-load path, each with a valid/ready handshake.
- Buffers results in a small in-order queue and drives the register file write port (reg_write_en / reg_write_dest / reg_write_data), one write per cycle.
- Exports a per-register pending mask so decode can stall on register hazards.

Parameters:
DATA_W, 16, datapath width; matches register file data width
ADDR_W, 4, register address width (16 registers)
FIFO_DEPTH, 4, queue entries; power of two, minimum 2
DROP_R0, 1, 1 = writes with dest 0 are accepted and discarded, never queued

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this edge when alu_valid=1
alu_dest  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result present
mem_ready  out  1  load result accepted this edge when mem_valid=1
mem_dest  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
reg_write_en  out  1  register file write strobe (registered)
reg_write_dest  out  ADDR_W  register file write address (registered)
reg_write_data  out  DATA_W  register file write data (registered)
busy_mask  out  2**ADDR_W  bit r set = write to register r queued or in flight
pending  out  1  OR of busy_mask

Behaviour:
- Reset, while rst=1 at an edge:
  - Queue flushed: pointers and count set to 0.
  - reg_write_en, reg_write_dest and reg_write_data set to 0.
  - alu_ready=0 and mem_ready=0 combinationally while rst=1.
  - Reset mid-operation discards all queued entries; no write issues for them.
- Handshake: transfer occurs on an edge where valid and ready are both 1. Producers hold dest/data stable while valid=1 and ready=0.
- Ready rules use free = FIFO_DEPTH - count, where count is registered and does not include a same-edge pop:
  - mem_ready = (free >= 1)
  - alu_ready = (free >= 2) or (free >= 1 and mem_valid = 0)
- Two pushes per edge are allowed. When both transfer on the same edge, the mem entry is enqueued ahead of the alu entry.
- Pop: one entry per edge whenever count > 0 at that edge. The popped entry loads reg_write_dest/data and sets reg_write_en=1 for the following cycle; otherwise reg_write_en=0.
- Latency: a result transferred on edge N into an empty queue appears as reg_write_en=1 during the cycle after edge N+1. The register file writes it at edge N+2.
- No pass-through when full. A same-edge pop does not raise ready.
- count update: next = count + pushes - pop. Never exceeds FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- DROP_R0=1 and dest=0: handshake completes (ready per the rules above), entry not enqueued, count unchanged.
- busy_mask[r] = 1 iff any valid queue entry has dest r, or (reg_write_en=1 and reg_write_dest=r). Combinational from state.
- Ordering: writes to the same register retire in enqueue order; the last write wins.

Optional Feature:
- Macro WB_FWD_EN.
- When defined, adds ports:
  - fwd_addr  in  ADDR_W
  - fwd_hit  out  1
  - fwd_data  out  DATA_W
- fwd_hit=1 when fwd_addr matches any valid queue entry or the in-flight output register.
- fwd_data is the youngest match: the newest queue entry first, then the output register. fwd_data=0 when there is no hit.
- Purely combinational.
- When the macro is not defined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- cpu_pkg holds:
  - DATA_W, REG_ADDR_W, NUM_REGS constants.
  - wb_entry_t struct {dest, data}.
- One sub-module, wb_fifo:
  - dual-push, single-pop circular queue;
  - exposes count and an entry-valid vector for busy_mask and forwarding.
- Top level holds the ready logic, r0 drop, output register and mask/forwarding.

Test Plan:
- Reset: rst=1 for 2 cycles with alu_valid=1, dest 5 -> alu_ready=0, reg_write_en=0, busy_mask=0. After release, nothing is written.
- Single write: alu dest 3, data 0x1234 on edge N -> reg_write_en=1, dest 3, data 0x1234 for exactly one cycle after edge N+1. busy_mask[3]=1 from after edge N until the write retires. Register file readback of r3 = 0x1234.
- Dual push: mem (dest 2, 0x5555) and alu (dest 1, 0xAAAA) on the same edge -> writes retire r2 first, then r1, on consecutive cycles.
- Fill, FIFO_DEPTH=4: both valid every cycle from empty -> count 2, then 3. From the third edge alu_ready=0 while mem_ready=1. Order of all writes is preserved.
- r0 drop: alu dest 0, data 0xFFFF -> handshake completes, reg_write_en stays 0, busy_mask[0]=0.
- WB_FWD_EN: queue r4=0x0001, then r4=0x0002; fwd_addr=4 -> fwd_hit=1, fwd_data=0x0002. fwd_addr=7 -> fwd_hit=0, fwd_data=0.
